// File: rtl/cache_refill_controller.sv
// Cache-side initiator for the main-memory block interface: 16-word line refills
// on reads, single strobed word stores on writes, with saturating statistics.
module cache_refill_controller #(
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned TIMEOUT      = 64,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic             req_write,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             req_ready,
  output logic             resp_valid,
  output logic [511:0]     resp_line,
  output logic             resp_err,
  output logic [31:0]      mem_address,
  output logic [31:0]      mem_dataIn,
  output logic             mem_RWMode,
  output logic             mem_hit,
  input  logic             mem_busy,
  input  logic [511:0]     mem_dataOut,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count
);

  localparam int unsigned WC_W = (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY + 1);
  localparam int unsigned TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_WAIT  = 3'd1,
    WR_SETUP = 3'd2,
    WR_PULSE = 3'd3,
    RESP     = 3'd4
  } state_t;

  state_t           r_state,       w_state;
  logic             r_req_ready,   w_req_ready;
  logic             r_resp_valid,  w_resp_valid;
  logic             r_resp_err,    w_resp_err;
  logic [511:0]     r_resp_line,   w_resp_line;
  logic [31:0]      r_mem_address, w_mem_address;
  logic [31:0]      r_mem_dataIn,  w_mem_dataIn;
  logic             r_mem_RWMode,  w_mem_RWMode;
  logic             r_mem_hit,     w_mem_hit;
  logic [CNT_W-1:0] r_rd_count,    w_rd_count;
  logic [CNT_W-1:0] r_wr_count,    w_wr_count;
  logic [WC_W-1:0]  r_wait_cnt,    w_wait_cnt;
  logic [TO_W-1:0]  r_tmo_cnt,     w_tmo_cnt;

  // The latched request lives in mem_address/mem_dataIn and in the chosen state path.
  always_comb begin
    w_state       = r_state;
    w_req_ready   = r_req_ready;
    w_resp_valid  = r_resp_valid;
    w_resp_err    = r_resp_err;
    w_resp_line   = r_resp_line;
    w_mem_address = r_mem_address;
    w_mem_dataIn  = r_mem_dataIn;
    w_mem_RWMode  = r_mem_RWMode;
    w_mem_hit     = r_mem_hit;
    w_rd_count    = r_rd_count;
    w_wr_count    = r_wr_count;
    w_wait_cnt    = r_wait_cnt;
    w_tmo_cnt     = r_tmo_cnt;

    case (r_state)
      IDLE: begin
        if (req_valid && r_req_ready) begin
          w_req_ready  = 1'b0;
          w_mem_RWMode = 1'b0;
          if (req_write) begin
            w_mem_address = req_addr;
            w_mem_dataIn  = req_wdata;
            w_mem_hit     = 1'b1;
            w_state       = WR_SETUP;
          end else begin
            w_mem_address = {req_addr[31:4], 4'b0000};
            w_mem_hit     = 1'b0;
            w_wait_cnt    = WC_W'(READ_LATENCY);
            w_tmo_cnt     = {TO_W{1'b0}};
            w_state       = RD_WAIT;
          end
        end else begin
          w_req_ready = 1'b1;
        end
      end

      RD_WAIT: begin
        if (r_wait_cnt != {WC_W{1'b0}}) begin
          w_wait_cnt = r_wait_cnt - WC_W'(1);
        end else if (!mem_busy) begin
          w_resp_line  = mem_dataOut;
          w_resp_valid = 1'b1;
          w_resp_err   = 1'b0;
          w_mem_hit    = 1'b1;
          w_rd_count   = (r_rd_count == {CNT_W{1'b1}}) ? r_rd_count : r_rd_count + CNT_W'(1);
          w_state      = RESP;
        end else if (r_tmo_cnt == TO_W'(TIMEOUT - 1)) begin
          // Abort: this busy edge is the TIMEOUT-th one spent waiting.
          w_resp_line  = {512{1'b0}};
          w_resp_valid = 1'b1;
          w_resp_err   = 1'b1;
          w_mem_hit    = 1'b1;
          w_state      = RESP;
        end else begin
          w_tmo_cnt = r_tmo_cnt + TO_W'(1);
        end
      end

      WR_SETUP: begin
        w_mem_RWMode = 1'b1;
        w_state      = WR_PULSE;
      end

      WR_PULSE: begin
        w_mem_RWMode = 1'b0;
        w_resp_valid = 1'b1;
        w_resp_err   = 1'b0;
        w_wr_count   = (r_wr_count == {CNT_W{1'b1}}) ? r_wr_count : r_wr_count + CNT_W'(1);
        w_state      = RESP;
      end

      RESP: begin
        w_resp_valid = 1'b0;
        w_resp_err   = 1'b0;
        w_req_ready  = 1'b1;
        w_state      = IDLE;
      end

      default: begin
        w_resp_valid = 1'b0;
        w_resp_err   = 1'b0;
        w_mem_RWMode = 1'b0;
        w_mem_hit    = 1'b1;
        w_req_ready  = 1'b1;
        w_state      = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_req_ready   <= 1'b1;
      r_resp_valid  <= 1'b0;
      r_resp_err    <= 1'b0;
      r_resp_line   <= {512{1'b0}};
      r_mem_address <= 32'h0000_0000;
      r_mem_dataIn  <= 32'h0000_0000;
      r_mem_RWMode  <= 1'b0;
      r_mem_hit     <= 1'b1;
      r_rd_count    <= {CNT_W{1'b0}};
      r_wr_count    <= {CNT_W{1'b0}};
      r_wait_cnt    <= {WC_W{1'b0}};
      r_tmo_cnt     <= {TO_W{1'b0}};
    end else begin
      r_state       <= w_state;
      r_req_ready   <= w_req_ready;
      r_resp_valid  <= w_resp_valid;
      r_resp_err    <= w_resp_err;
      r_resp_line   <= w_resp_line;
      r_mem_address <= w_mem_address;
      r_mem_dataIn  <= w_mem_dataIn;
      r_mem_RWMode  <= w_mem_RWMode;
      r_mem_hit     <= w_mem_hit;
      r_rd_count    <= w_rd_count;
      r_wr_count    <= w_wr_count;
      r_wait_cnt    <= w_wait_cnt;
      r_tmo_cnt     <= w_tmo_cnt;
    end
  end

  assign req_ready   = r_req_ready;
  assign resp_valid  = r_resp_valid;
  assign resp_err    = r_resp_err;
  assign resp_line   = r_resp_line;
  assign mem_address = r_mem_address;
  assign mem_dataIn  = r_mem_dataIn;
  assign mem_RWMode  = r_mem_RWMode;
  assign mem_hit     = r_mem_hit;
  assign rd_count    = r_rd_count;
  assign wr_count    = r_wr_count;

endmodule

// File: tb/tb_cache_refill_controller.sv
// Directed bench for cache_refill_controller with a 512-word behavioural memory.
module tb_cache_refill_controller;

  logic         clk;
  logic         reset;
  logic         req_valid;
  logic         req_write;
  logic [31:0]  req_addr;
  logic [31:0]  req_wdata;
  logic         req_ready;
  logic         resp_valid;
  logic [511:0] resp_line;
  logic         resp_err;
  logic [31:0]  mem_address;
  logic [31:0]  mem_dataIn;
  logic         mem_RWMode;
  logic         mem_hit;
  logic         mem_busy;
  logic [511:0] mem_dataOut;
  logic [3:0]   rd_count;
  logic [3:0]   wr_count;

  logic [31:0]  mem [0:511];
  logic         mem_init;
  logic         prev_rw;
  int           rise_cnt;
  int           n_cmp;
  int           n_fail;

  cache_refill_controller #(
    .READ_LATENCY(2),
    .TIMEOUT(8),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_write(req_write),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_ready(req_ready),
    .resp_valid(resp_valid),
    .resp_line(resp_line),
    .resp_err(resp_err),
    .mem_address(mem_address),
    .mem_dataIn(mem_dataIn),
    .mem_RWMode(mem_RWMode),
    .mem_hit(mem_hit),
    .mem_busy(mem_busy),
    .mem_dataOut(mem_dataOut),
    .rd_count(rd_count),
    .wr_count(wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory commits a word on each rising edge of mem_RWMode seen at a clock edge.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 512; i++) mem[i] <= i;
      rise_cnt <= 0;
    end else if (mem_RWMode && !prev_rw) begin
      mem[mem_address[8:0]] <= mem_dataIn;
      rise_cnt <= rise_cnt + 1;
    end
    prev_rw <= mem_RWMode;
  end

  always_comb begin
    mem_dataOut = '0;
    for (int k = 0; k < 16; k++)
      mem_dataOut[32*k +: 32] = mem_hit ? 32'h0 : mem[{mem_address[8:4], k[3:0]}];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; mem_init = 1'b1;
    tick; tick;
    mem_init = 1'b0;
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    n_cmp++; if ({resp_valid, resp_err, mem_RWMode, mem_hit} !== 4'b0001) begin n_fail++; $display("FAIL reset_flags: got %b want 0001", {resp_valid, resp_err, mem_RWMode, mem_hit}); end
    n_cmp++; if (resp_line !== 512'h0) begin n_fail++; $display("FAIL reset_line: got nonzero want 0"); end
    n_cmp++; if ({mem_address, mem_dataIn} !== 64'h0) begin n_fail++; $display("FAIL reset_mem_bus: got %h want 0", {mem_address, mem_dataIn}); end
    n_cmp++; if ({rd_count, wr_count} !== 8'h00) begin n_fail++; $display("FAIL reset_counts: got %h want 00", {rd_count, wr_count}); end
    reset = 1'b0;
    tick;
    n_cmp++; if (req_ready !== 1'b1 || mem_hit !== 1'b1) begin n_fail++; $display("FAIL idle_after_reset: got ready=%b hit=%b want 1 1", req_ready, mem_hit); end
  endtask

  task automatic test_read;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0023;
    tick;
    req_valid = 1'b0;
    n_cmp++; if (mem_address !== 32'h20 || mem_hit !== 1'b0) begin n_fail++; $display("FAIL rd_issue: got addr=%h hit=%b want 20 0", mem_address, mem_hit); end
    n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rd_busy_ready: got %b want 0", req_ready); end
    tick;
    n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rd_early1: got %b want 0", resp_valid); end
    tick;
    n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rd_early2: got %b want 0", resp_valid); end
    tick;
    n_cmp++; if (resp_valid !== 1'b1 || resp_err !== 1'b0) begin n_fail++; $display("FAIL rd_resp: got v=%b e=%b want 1 0", resp_valid, resp_err); end
    n_cmp++; if (resp_line[31:0] !== 32'h20 || resp_line[511:480] !== 32'h2F) begin n_fail++; $display("FAIL rd_line: got w0=%h w15=%h want 20 2f", resp_line[31:0], resp_line[511:480]); end
    n_cmp++; if (rd_count !== 4'd1 || mem_hit !== 1'b1) begin n_fail++; $display("FAIL rd_count: got cnt=%h hit=%b want 1 1", rd_count, mem_hit); end
    tick;
    n_cmp++; if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_line[63:32] !== 32'h21) begin n_fail++; $display("FAIL rd_done: got v=%b rdy=%b w1=%h want 0 1 21", resp_valid, req_ready, resp_line[63:32]); end
  endtask

  task automatic test_write;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_0105; req_wdata = 32'hDEAD_BEEF;
    tick;
    req_valid = 1'b0;
    n_cmp++; if (mem_address !== 32'h105 || mem_dataIn !== 32'hDEADBEEF || mem_RWMode !== 1'b0) begin n_fail++; $display("FAIL wr_setup: got a=%h d=%h rw=%b want 105 deadbeef 0", mem_address, mem_dataIn, mem_RWMode); end
    tick;
    n_cmp++; if (mem_RWMode !== 1'b1 || mem_address !== 32'h105 || mem_dataIn !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_strobe: got rw=%b a=%h d=%h want 1 105 deadbeef", mem_RWMode, mem_address, mem_dataIn); end
    tick;
    n_cmp++; if (mem_RWMode !== 1'b0 || resp_valid !== 1'b1 || wr_count !== 4'd1) begin n_fail++; $display("FAIL wr_ack: got rw=%b v=%b cnt=%h want 0 1 1", mem_RWMode, resp_valid, wr_count); end
    n_cmp++; if (rise_cnt !== 1 || mem[9'h105] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_mem: got rises=%0d word=%h want 1 deadbeef", rise_cnt, mem[9'h105]); end
    tick;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0100;
    tick;
    req_valid = 1'b0;
    tick; tick; tick;
    n_cmp++; if (resp_valid !== 1'b1 || resp_line[191:160] !== 32'hDEADBEEF || resp_line[31:0] !== 32'h100) begin n_fail++; $display("FAIL wr_readback: got v=%b w5=%h w0=%h want 1 deadbeef 100", resp_valid, resp_line[191:160], resp_line[31:0]); end
    tick;
  endtask

  task automatic test_addr_wrap;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'hFFFF_FFFF;
    tick;
    req_valid = 1'b0;
    n_cmp++; if (mem_address !== 32'hFFFF_FFF0) begin n_fail++; $display("FAIL wrap_addr: got %h want fffffff0", mem_address); end
    tick; tick; tick;
    n_cmp++; if (resp_line[31:0] !== 32'h1F0 || resp_line[511:480] !== 32'h1FF || rd_count !== 4'd3) begin n_fail++; $display("FAIL wrap_line: got w0=%h w15=%h cnt=%h want 1f0 1ff 3", resp_line[31:0], resp_line[511:480], rd_count); end
    tick;
  endtask

  task automatic test_back_to_back;
    int acc;
    int resp;
    logic rdy;
    acc = 0; resp = 0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h40; req_wdata = 32'h0;
    for (int cyc = 0; cyc < 80 && acc < 4; cyc++) begin
      rdy = req_ready;
      tick;
      if (resp_valid) resp++;
      if (rdy) begin
        n_cmp++; if (resp !== acc) begin n_fail++; $display("FAIL b2b_order: got resp=%0d want %0d at accept", resp, acc); end
        acc++;
        case (acc)
          1: begin req_write = 1'b1; req_addr = 32'h41; req_wdata = 32'hA5A5_0001; end
          2: begin req_write = 1'b0; req_addr = 32'h60; end
          3: begin req_write = 1'b1; req_addr = 32'h62; req_wdata = 32'h5A5A_0003; end
          default: req_valid = 1'b0;
        endcase
      end
    end
    req_valid = 1'b0;
    for (int cyc = 0; cyc < 20 && resp < 4; cyc++) begin
      tick;
      if (resp_valid) resp++;
    end
    tick;
    n_cmp++; if (acc !== 4 || resp !== 4) begin n_fail++; $display("FAIL b2b_counts: got acc=%0d resp=%0d want 4 4", acc, resp); end
    n_cmp++; if (rd_count !== 4'd5 || wr_count !== 4'd3) begin n_fail++; $display("FAIL b2b_stats: got rd=%h wr=%h want 5 3", rd_count, wr_count); end
    n_cmp++; if (mem[9'h041] !== 32'hA5A50001 || mem[9'h062] !== 32'h5A5A0003 || rise_cnt !== 3) begin n_fail++; $display("FAIL b2b_mem: got %h %h rises=%0d want a5a50001 5a5a0003 3", mem[9'h041], mem[9'h062], rise_cnt); end
  endtask

  task automatic test_timeout;
    int n;
    n = 0;
    mem_busy = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h80;
    tick;
    req_valid = 1'b0;
    while (!resp_valid && n < 30) begin
      tick;
      n++;
    end
    n_cmp++; if (n !== 10) begin n_fail++; $display("FAIL tmo_latency: got %0d edges want 10", n); end
    n_cmp++; if (resp_err !== 1'b1 || resp_line !== 512'h0 || mem_hit !== 1'b1) begin n_fail++; $display("FAIL tmo_resp: got err=%b line0=%h hit=%b want 1 0 1", resp_err, resp_line[31:0], mem_hit); end
    n_cmp++; if (rd_count !== 4'd5) begin n_fail++; $display("FAIL tmo_count: got %h want 5", rd_count); end
    mem_busy = 1'b0;
    tick;
    n_cmp++; if (resp_err !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL tmo_clear: got e=%b v=%b rdy=%b want 0 0 1", resp_err, resp_valid, req_ready); end
  endtask

  task automatic test_reset_midflight;
    logic seen;
    int rises;
    rises = rise_cnt;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h1A0; req_wdata = 32'h1234_5678;
    tick;
    req_valid = 1'b0;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    tick;
    n_cmp++; if (mem_RWMode !== 1'b0 || rise_cnt !== rises || mem[9'h1A0] !== 32'h1A0) begin n_fail++; $display("FAIL rst_wr_setup: got rw=%b rises=%0d word=%h want 0 %0d 1a0", mem_RWMode, rise_cnt, mem[9'h1A0], rises); end
    n_cmp++; if (req_ready !== 1'b1 || wr_count !== 4'd0) begin n_fail++; $display("FAIL rst_wr_setup_state: got rdy=%b wr=%h want 1 0", req_ready, wr_count); end

    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h40;
    tick;
    req_valid = 1'b0;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    n_cmp++; if ({req_ready, resp_valid, resp_err, mem_RWMode, mem_hit} !== 5'b10001 || resp_line !== 512'h0) begin n_fail++; $display("FAIL rst_rd_flags: got %b want 10001", {req_ready, resp_valid, resp_err, mem_RWMode, mem_hit}); end
    n_cmp++; if ({mem_address, mem_dataIn} !== 64'h0 || {rd_count, wr_count} !== 8'h0) begin n_fail++; $display("FAIL rst_rd_regs: got addr=%h cnt=%h want 0 0", mem_address, {rd_count, wr_count}); end
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (resp_valid || !mem_hit) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_rd_quiet: got activity=%b want 0", seen); end

    rises = rise_cnt;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h1B0; req_wdata = 32'hCAFE_F00D;
    tick;
    req_valid = 1'b0;
    tick;
    n_cmp++; if (mem_RWMode !== 1'b1) begin n_fail++; $display("FAIL rst_wr_pulse_pre: got rw=%b want 1", mem_RWMode); end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    n_cmp++; if (mem[9'h1B0] !== 32'hCAFEF00D || rise_cnt !== rises + 1) begin n_fail++; $display("FAIL rst_wr_pulse_commit: got word=%h rises=%0d want cafef00d %0d", mem[9'h1B0], rise_cnt, rises + 1); end
    n_cmp++; if (resp_valid !== 1'b0 || wr_count !== 4'd0 || mem_RWMode !== 1'b0) begin n_fail++; $display("FAIL rst_wr_pulse_noack: got v=%b wr=%h rw=%b want 0 0 0", resp_valid, wr_count, mem_RWMode); end
    tick;
  endtask

  task automatic test_saturation;
    logic [3:0] exp_wr;
    exp_wr = 4'd0;
    for (int i = 0; i < 17; i++) begin
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h1C0 + i; req_wdata = i;
      tick;
      req_valid = 1'b0;
      tick; tick;
      exp_wr = (exp_wr == 4'hF) ? 4'hF : exp_wr + 4'd1;
      n_cmp++; if (wr_count !== exp_wr || resp_valid !== 1'b1) begin n_fail++; $display("FAIL sat_write%0d: got cnt=%h v=%b want %h 1", i, wr_count, resp_valid, exp_wr); end
      tick;
    end
    n_cmp++; if (wr_count !== 4'hF || rd_count !== 4'h0) begin n_fail++; $display("FAIL sat_final: got wr=%h rd=%h want f 0", wr_count, rd_count); end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    reset = 1'b1; mem_init = 1'b1; mem_busy = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    test_reset;
    test_read;
    test_write;
    test_addr_wrap;
    test_back_to_back;
    test_timeout;
    test_reset_midflight;
    test_saturation;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
